// File: rtl/nanaseg_readback_pkg.sv
// Shared constants and types for the 7-segment display readback monitor:
// digit segment patterns, select-bit positions, slot/state enums and helpers.
package nanaseg_pkg;

    // Digit select bits on the display bus (active high)
    localparam int SEL_ONES_BIT = 7;
    localparam int SEL_TENS_BIT = 8;
    localparam int SEL_HUND_BIT = 11;
    localparam logic [11:0] SEL_MASK = 12'h980;

    // Segment patterns (active-low segments, select bits cleared)
    localparam logic [11:0] PAT_0 = 12'b000000010100;
    localparam logic [11:0] PAT_1 = 12'b011000010111;
    localparam logic [11:0] PAT_2 = 12'b001000001100;
    localparam logic [11:0] PAT_3 = 12'b001000000101;
    localparam logic [11:0] PAT_4 = 12'b010000000111;
    localparam logic [11:0] PAT_5 = 12'b000001000101;
    localparam logic [11:0] PAT_6 = 12'b000001000100;
    localparam logic [11:0] PAT_7 = 12'b000000010111;
    localparam logic [11:0] PAT_8 = 12'b000000000100;
    localparam logic [11:0] PAT_9 = 12'b000000000101;

    // Indexed by digit value
    localparam logic [9:0][11:0] DIGIT_PATS = {PAT_9, PAT_8, PAT_7, PAT_6, PAT_5,
                                               PAT_4, PAT_3, PAT_2, PAT_1, PAT_0};

    typedef enum logic [2:0] {
        SLOT_NONE,
        SLOT_ONES,
        SLOT_TENS,
        SLOT_HUNDREDS,
        SLOT_BAD
    } slot_t;

    typedef enum logic [1:0] {
        WAIT_ONES,
        HAVE_ONES,
        HAVE_TENS
    } state_t;

    // Which digit slot a bus sample belongs to; zero or several selects are unusable
    function automatic slot_t classify_select(input logic [11:0] bus_word);
        slot_t slot;
        case ({bus_word[SEL_HUND_BIT], bus_word[SEL_TENS_BIT], bus_word[SEL_ONES_BIT]})
            3'b000:  slot = SLOT_NONE;
            3'b001:  slot = SLOT_ONES;
            3'b010:  slot = SLOT_TENS;
            3'b100:  slot = SLOT_HUNDREDS;
            default: slot = SLOT_BAD;
        endcase
        return slot;
    endfunction

    // Three BCD digits to binary; digits are 0-9 so the result never exceeds 999
    function automatic logic [10:0] bcd3_to_bin(input logic [3:0] h,
                                                input logic [3:0] t,
                                                input logic [3:0] o);
        return 11'(h) * 11'd100 + 11'(t) * 11'd10 + 11'(o);
    endfunction

endpackage

// File: rtl/nanaseg_readback_if.sv
// Display bus sample in, decoded score and status flags out.
// slave: the monitor itself; master: whoever drives the bus and reads results.
interface nanaseg_readback_if #(
    parameter int ERR_CNT_W = 8
);
    logic [11:0]          seg_in;
    logic [10:0]          score;
    logic                 score_valid;
    logic                 frame_valid;
    logic                 score_changed;
    logic                 sync_err;
    logic                 pat_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output seg_in,
        input  score, score_valid, frame_valid, score_changed,
        input  sync_err, pat_err, err_count
    );

    modport slave (
        input  seg_in,
        output score, score_valid, frame_valid, score_changed,
        output sync_err, pat_err, err_count
    );
endinterface

// File: rtl/nanaseg_pattern_to_digit.sv
// Combinational segment-pattern to BCD digit decoder. The pattern must already
// have the select bits cleared; anything outside the ten known shapes is invalid.
module nanaseg_pattern_to_digit
    import nanaseg_pkg::*;
(
    input  logic [11:0] pattern,
    output logic [3:0]  digit,
    output logic        valid
);
    logic [9:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_cmp
            assign hit[gi] = (pattern == DIGIT_PATS[gi]);
        end
    endgenerate

    // Encode the (at most one) matching pattern into its digit value
    always_comb begin
        digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (hit[i]) begin
                digit = 4'(i);
            end
        end
    end

    assign valid = |hit;
endmodule

// File: rtl/nanaseg_readback.sv
// Display-bus monitor: registers the segment/select bus, reassembles
// ones/tens/hundreds frames, debounces the score and counts bus errors.
module nanaseg_readback
    import nanaseg_pkg::*;
#(
    parameter int STABLE_FRAMES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic               CLOCK10M,
    input  logic               RESET_N,
    nanaseg_readback_if.slave  bus
);
    localparam logic [3:0] STABLE_CNT = 4'(STABLE_FRAMES);

    // Input stage; seg_vld_reg marks that seg_reg holds a real sample rather
    // than its reset value, so the first cycle after reset is not an error.
    logic [11:0] seg_reg;
    logic        seg_vld_reg;

    // Frame assembly
    state_t      state_reg, state_next;
    logic [3:0]  ones_reg, ones_next;
    logic [3:0]  tens_reg, tens_next;
    logic        frame_fire, sync_fire, pat_fire;

    // Debounce and outputs
    logic [10:0]          cand_reg, cand_next;
    logic [3:0]           match_reg, match_next;
    logic [10:0]          score_reg, score_next;
    logic                 score_valid_reg, score_valid_next;
    logic                 score_changed_next;
    logic                 score_changed_reg;
    logic                 frame_valid_reg;
    logic                 sync_err_reg;
    logic                 pat_err_reg;
    logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;

    slot_t       slot;
    logic [11:0] seg_mask;
    logic [3:0]  digit;
    logic        digit_ok;
    logic [10:0] frame_value;

    assign slot     = classify_select(seg_reg);
    assign seg_mask = seg_reg & ~SEL_MASK;

    nanaseg_pattern_to_digit u_decode (
        .pattern (seg_mask),
        .digit   (digit),
        .valid   (digit_ok)
    );

    // Current sample is the hundreds digit whenever a frame completes
    assign frame_value = bcd3_to_bin(digit, tens_reg, ones_reg);

    // Register the raw display bus once on entry
    always_ff @(posedge CLOCK10M or negedge RESET_N) begin
        if (!RESET_N) begin
            seg_reg     <= '0;
            seg_vld_reg <= 1'b0;
        end else begin
            seg_reg     <= bus.seg_in;
            seg_vld_reg <= 1'b1;
        end
    end

    // Frame FSM next state, digit capture and event decode
    always_comb begin
        state_next = state_reg;
        ones_next  = ones_reg;
        tens_next  = tens_reg;
        frame_fire = 1'b0;
        sync_fire  = 1'b0;
        pat_fire   = 1'b0;
        if (seg_vld_reg) begin
            if (slot == SLOT_NONE || slot == SLOT_BAD) begin
                pat_fire   = 1'b1;
                state_next = WAIT_ONES;
            end else begin
                case (state_reg)
                    WAIT_ONES: begin
                        // Tens/hundreds here are just the rotation before lock-on
                        if (slot == SLOT_ONES) begin
                            if (digit_ok) begin
                                ones_next  = digit;
                                state_next = HAVE_ONES;
                            end else begin
                                pat_fire = 1'b1;
                            end
                        end
                    end
                    HAVE_ONES: begin
                        if (!digit_ok) begin
                            pat_fire   = 1'b1;
                            state_next = WAIT_ONES;
                        end else if (slot == SLOT_TENS) begin
                            tens_next  = digit;
                            state_next = HAVE_TENS;
                        end else if (slot == SLOT_ONES) begin
                            sync_fire  = 1'b1;
                            ones_next  = digit;
                            state_next = HAVE_ONES;
                        end else begin
                            sync_fire  = 1'b1;
                            state_next = WAIT_ONES;
                        end
                    end
                    HAVE_TENS: begin
                        if (!digit_ok) begin
                            pat_fire   = 1'b1;
                            state_next = WAIT_ONES;
                        end else if (slot == SLOT_HUNDREDS) begin
                            frame_fire = 1'b1;
                            state_next = WAIT_ONES;
                        end else if (slot == SLOT_ONES) begin
                            sync_fire  = 1'b1;
                            ones_next  = digit;
                            state_next = HAVE_ONES;
                        end else begin
                            sync_fire  = 1'b1;
                            state_next = WAIT_ONES;
                        end
                    end
                    default: state_next = WAIT_ONES;
                endcase
            end
        end
    end

    // Debounce completed frames into the published score; count errors
    always_comb begin
        cand_next          = cand_reg;
        match_next         = match_reg;
        score_next         = score_reg;
        score_valid_next   = score_valid_reg;
        score_changed_next = 1'b0;
        err_count_next     = err_count_reg;
        if (pat_fire || sync_fire) begin
            match_next = '0;
            if (err_count_reg != '1) begin
                err_count_next = err_count_reg + 1'b1;
            end
        end else if (frame_fire) begin
            if (frame_value == cand_reg) begin
                match_next = (match_reg >= STABLE_CNT) ? STABLE_CNT : match_reg + 4'd1;
            end else begin
                cand_next  = frame_value;
                match_next = 4'd1;
            end
            if (match_next == STABLE_CNT &&
                (score_reg != cand_next || !score_valid_reg)) begin
                score_next         = cand_next;
                score_valid_next   = 1'b1;
                score_changed_next = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg         <= WAIT_ONES;
            ones_reg          <= '0;
            tens_reg          <= '0;
            cand_reg          <= '0;
            match_reg         <= '0;
            score_reg         <= '0;
            score_valid_reg   <= 1'b0;
            score_changed_reg <= 1'b0;
            frame_valid_reg   <= 1'b0;
            sync_err_reg      <= 1'b0;
            pat_err_reg       <= 1'b0;
            err_count_reg     <= '0;
        end else begin
            state_reg         <= state_next;
            ones_reg          <= ones_next;
            tens_reg          <= tens_next;
            cand_reg          <= cand_next;
            match_reg         <= match_next;
            score_reg         <= score_next;
            score_valid_reg   <= score_valid_next;
            score_changed_reg <= score_changed_next;
            frame_valid_reg   <= frame_fire;
            sync_err_reg      <= sync_fire;
            pat_err_reg       <= pat_fire;
            err_count_reg     <= err_count_next;
        end
    end

    assign bus.score         = score_reg;
    assign bus.score_valid   = score_valid_reg;
    assign bus.frame_valid   = frame_valid_reg;
    assign bus.score_changed = score_changed_reg;
    assign bus.sync_err      = sync_err_reg;
    assign bus.pat_err       = pat_err_reg;
    assign bus.err_count     = err_count_reg;
endmodule

// File: tb/tb_nanaseg_readback.sv
// Directed testbench for the display readback monitor. Each drive applies one
// bus sample for one clock; outputs observed after that edge reflect the
// sample driven one step earlier (two-edge latency).
module tb_nanaseg_readback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] SEL_O = 12'h080;
    localparam logic [11:0] SEL_T = 12'h100;
    localparam logic [11:0] SEL_H = 12'h800;
    localparam logic [11:0] P [10] = '{12'h014, 12'h617, 12'h20C, 12'h205, 12'h407,
                                       12'h045, 12'h044, 12'h017, 12'h004, 12'h005};
    localparam logic [11:0] BLANK_ONES = 12'h6FF;  // all segments off, ones select
    localparam logic [11:0] BAD_SEL    = 12'h184;  // digit 8 with ones+tens selects

    nanaseg_readback_if #(.ERR_CNT_W(8)) bus_if ();

    nanaseg_readback #(.STABLE_FRAMES(2), .ERR_CNT_W(8)) dut (
        .CLOCK10M (clk),
        .RESET_N  (rst_n),
        .bus      (bus_if)
    );

    always #50 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic fv, input logic chg,
                             input logic sv, input int score, input logic sync,
                             input logic pat, input int errc);
        check({tag, ".frame_valid"},   32'(bus_if.frame_valid),   32'(fv));
        check({tag, ".score_changed"}, 32'(bus_if.score_changed), 32'(chg));
        check({tag, ".score_valid"},   32'(bus_if.score_valid),   32'(sv));
        check({tag, ".score"},         32'(bus_if.score),         32'(score));
        check({tag, ".sync_err"},      32'(bus_if.sync_err),      32'(sync));
        check({tag, ".pat_err"},       32'(bus_if.pat_err),       32'(pat));
        check({tag, ".err_count"},     32'(bus_if.err_count),     32'(errc));
    endtask

    task automatic drive(input logic [11:0] v);
        bus_if.seg_in = v;
        @(posedge clk);
        #1;
        $display("t=%0t seg_in=%03h fv=%0b score=%0d chg=%0b sv=%0b sync=%0b pat=%0b errc=%0d",
                 $time, v, bus_if.frame_valid, bus_if.score, bus_if.score_changed,
                 bus_if.score_valid, bus_if.sync_err, bus_if.pat_err, bus_if.err_count);
    endtask

    // One clean ones/tens/hundreds rotation. The ones step reports the previous
    // sample (expected flags given); tens and hundreds steps must be quiet.
    task automatic frame(input string tag, input int o, input int t, input int h,
                         input logic efv, input logic echg, input logic esv,
                         input int escore, input int errc);
        drive(SEL_O | P[o]);
        check_out({tag, "/o"}, efv, echg, esv, escore, 1'b0, 1'b0, errc);
        drive(SEL_T | P[t]);
        check_out({tag, "/t"}, 1'b0, 1'b0, esv, escore, 1'b0, 1'b0, errc);
        drive(SEL_H | P[h]);
        check_out({tag, "/h"}, 1'b0, 1'b0, esv, escore, 1'b0, 1'b0, errc);
    endtask

    task automatic do_reset(input string tag);
        #10;
        rst_n = 1'b0;
        #1;
        check_out({tag, "/async"}, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_out({tag, "/held"}, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        bus_if.seg_in = SEL_O | P[7];
        // Power-on reset
        @(posedge clk);
        @(posedge clk);
        #1;
        check_out("por", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;

        // 427 rotation: frame_valid every third cycle, score on second frame
        frame("r427a", 7, 2, 4, 1'b0, 1'b0, 1'b0, 0,   0);
        frame("r427b", 7, 2, 4, 1'b1, 1'b0, 1'b0, 0,   0);
        frame("r427c", 7, 2, 4, 1'b1, 1'b1, 1'b1, 427, 0);
        frame("r427d", 7, 2, 4, 1'b1, 1'b0, 1'b1, 427, 0);

        // One-frame glitch to 428 and back: score must not move
        frame("g428",  8, 2, 4, 1'b1, 1'b0, 1'b1, 427, 0);
        frame("gback", 7, 2, 4, 1'b1, 1'b0, 1'b1, 427, 0);
        frame("g427a", 7, 2, 4, 1'b1, 1'b0, 1'b1, 427, 0);
        frame("g427b", 7, 2, 4, 1'b1, 1'b0, 1'b1, 427, 0);

        // Tens straight after tens while holding tens: one sync error
        drive(SEL_O | P[7]);
        check_out("sync0", 1'b1, 1'b0, 1'b1, 427, 1'b0, 1'b0, 0);
        drive(SEL_T | P[2]);
        check_out("sync1", 1'b0, 1'b0, 1'b1, 427, 1'b0, 1'b0, 0);
        drive(SEL_T | P[2]);
        check_out("sync2", 1'b0, 1'b0, 1'b1, 427, 1'b0, 1'b0, 0);
        drive(SEL_O | P[7]);
        check_out("sync3", 1'b0, 1'b0, 1'b1, 427, 1'b1, 1'b0, 1);
        drive(SEL_T | P[2]);
        check_out("sync4", 1'b0, 1'b0, 1'b1, 427, 1'b0, 1'b0, 1);
        drive(SEL_H | P[4]);
        check_out("sync5", 1'b0, 1'b0, 1'b1, 427, 1'b0, 1'b0, 1);
        frame("resync_a", 7, 2, 4, 1'b1, 1'b0, 1'b1, 427, 1);
        frame("resync_b", 7, 2, 4, 1'b1, 1'b0, 1'b1, 427, 1);

        // Blank ones and double select: two pattern errors (err_count 1 -> 3)
        drive(BLANK_ONES);
        check_out("pat0", 1'b1, 1'b0, 1'b1, 427, 1'b0, 1'b0, 1);
        drive(BAD_SEL);
        check_out("pat1", 1'b0, 1'b0, 1'b1, 427, 1'b0, 1'b1, 2);
        drive(SEL_T | P[2]);
        check_out("pat2", 1'b0, 1'b0, 1'b1, 427, 1'b0, 1'b1, 3);
        // Frame aborted by a bad select in place of hundreds: no frame_valid
        drive(SEL_O | P[1]);
        check_out("abort0", 1'b0, 1'b0, 1'b1, 427, 1'b0, 1'b0, 3);
        drive(SEL_T | P[2]);
        check_out("abort1", 1'b0, 1'b0, 1'b1, 427, 1'b0, 1'b0, 3);
        drive(BAD_SEL);
        check_out("abort2", 1'b0, 1'b0, 1'b1, 427, 1'b0, 1'b0, 3);
        drive(SEL_H | P[4]);
        check_out("abort3", 1'b0, 1'b0, 1'b1, 427, 1'b0, 1'b1, 4);
        drive(SEL_T | P[2]);
        check_out("abort4", 1'b0, 1'b0, 1'b1, 427, 1'b0, 1'b0, 4);

        // Boundaries 000 then 999 from a fresh reset
        do_reset("rst_b");
        frame("b000a", 0, 0, 0, 1'b0, 1'b0, 1'b0, 0,   0);
        frame("b000b", 0, 0, 0, 1'b1, 1'b0, 1'b0, 0,   0);
        frame("b999a", 9, 9, 9, 1'b1, 1'b1, 1'b1, 0,   0);
        frame("b999b", 9, 9, 9, 1'b1, 1'b0, 1'b1, 0,   0);
        frame("bpost", 7, 2, 4, 1'b1, 1'b1, 1'b1, 999, 0);

        // Reset asserted while holding tens, released on a tens sample
        drive(SEL_O | P[7]);
        check_out("mid0", 1'b1, 1'b0, 1'b1, 999, 1'b0, 1'b0, 0);
        drive(SEL_T | P[2]);
        check_out("mid1", 1'b0, 1'b0, 1'b1, 999, 1'b0, 1'b0, 0);
        drive(SEL_H | P[4]);
        check_out("mid2", 1'b0, 1'b0, 1'b1, 999, 1'b0, 1'b0, 0);
        bus_if.seg_in = SEL_T | P[2];
        do_reset("rst_mid");
        drive(SEL_T | P[2]);
        check_out("rel0", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        drive(SEL_H | P[4]);
        check_out("rel1", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        frame("rel_a", 7, 2, 4, 1'b0, 1'b0, 1'b0, 0,   0);
        frame("rel_b", 7, 2, 4, 1'b1, 1'b0, 1'b0, 0,   0);
        frame("rel_c", 0, 0, 0, 1'b1, 1'b1, 1'b1, 427, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
